pipelined_segment_adder: RTL and testbench
==========================================

// Module: pipelined_segment_adder
// PURPOSE
// - Parametrised, pipelined successor to the single-cycle registered ripple adder.
// - Splits a WIDTH-bit add into STAGES = WIDTH/SEG segments, one segment per pipeline stage.
// - Carry is registered between stages; throughput is one add per cycle.
// - valid/ready handshake on input and output; stalls propagate stage by stage.
// - Sits in the datapath wherever wide adds must close timing at high clk frequency.
// PARAMETERS
// - WIDTH  32  operand and sum width in bits; must be a multiple of SEG.
// - SEG    8   segment width in bits. STAGES = WIDTH/SEG, range 1..WIDTH.
// PORTS
// - clk        in   1      single clock; all state updates on posedge.
// - rst_n      in   1      synchronous, active-low reset.
// - in_valid   in   1      A/B/Cin are valid this cycle.
// - in_ready   out  1      block accepts an operand set this cycle.
// - A          in   WIDTH  operand A.
// - B          in   WIDTH  operand B.
// - Cin        in   1      carry into bit 0.
// - out_valid  out  1      S/Cout hold a completed result.
// - out_ready  in   1      downstream accepts the result this cycle.
// - S          out  WIDTH  sum, i.e. (A + B + Cin) mod 2^WIDTH.
// - Cout       out  1      carry out of bit WIDTH-1.
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all stage valid bits clear; S=0, Cout=0, out_valid=0.
//   - in_ready=1 in the cycle after reset.
//   - Reset mid-operation discards every in-flight result; none is ever emitted.
// - Transfers:
//   - Input transfer = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
// - Stage k (0..STAGES-1) holds v[k], the partial sum, the carry and the not-yet-added operand bits.
//   - Stage k adds segment k: bits [k*SEG +: SEG] of A, B and the incoming carry.
//   - Stage 0 uses Cin as its carry. Stage k>0 uses the registered carry from stage k-1.
//   - Upper operand segments are delayed alongside the data; lower sum segments pass forward unchanged.
// - Stall rule (bubble-collapsing):
//   - ready[k] = !v[k] | ready[k+1].
//   - ready[STAGES] = out_ready.
//   - in_ready = ready[0].
//   - Stage k loads from stage k-1 iff ready[k]. It sets v[k] = v[k-1] (in_valid for k=0).
// - Output stage = last stage: S, Cout and out_valid are registers, with no combinational path from A/B.
// - Latency: a result is visible STAGES cycles after its input transfer, when not stalled.
//   - STAGES=1 gives exactly the registered single-cycle adder.
// - out_valid & !out_ready: S and Cout hold stable until the transfer happens.
// - Full pipeline with out_ready=1: an input and an output transfer in the same cycle is legal.
//   - Sustained throughput is one result per cycle.
// - Full pipeline with out_ready=0: in_ready=0. A/B/Cin are ignored while in_valid & !in_ready.
// - Results leave in input order. No result is dropped or duplicated.
// - Wrap-around: S is truncated to WIDTH. Cout is the true carry (e.g. all-ones + 1 gives S=0, Cout=1).
// - WIDTH % SEG != 0, or SEG > WIDTH: elaboration-time $error.
// CONFIGURATION
// - Macro ADD_SUB_MODE_EN defined:
//   - Adds input port `sub` (1 bit), which travels with its operands.
//   - sub=1: S = A + ~B + !Cin, i.e. A - B - Cin with Cin acting as borrow-in; Cout = !borrow-out.
//   - sub=0: identical to plain add.
// - Macro not defined: no `sub` port; add only. Port list and timing are otherwise identical.
// TESTING
// - The reference model is the unsegmented A+B+Cin in 33 bits, checked per output transfer.
// - Bench default is WIDTH=32, SEG=8 (latency 4).
// 1. Reset then A=0xFFFFFFFF, B=0x00000001, Cin=0 -> after 4 cycles S=0x00000000, Cout=1.
// 2. A=0x000000FF, B=0x00000001, Cin=1 -> S=0x00000101, Cout=0.
//    - Checks the carry crossing the seg0->seg1 boundary.
// 3. 16 back-to-back random inputs with out_ready=1 -> 16 outputs on consecutive cycles, in order.
//    - in_ready stays high throughout.
// 4. Fill the pipeline, hold out_ready=0 for 5 cycles:
//    - in_ready drops after 4 accepts; S/Cout stay stable.
//    - Releasing out_ready drains all 4 results correctly.
// 5. Pull rst_n low for 1 cycle with 3 results in flight -> out_valid=0, S=0, Cout=0.
//    - No stale result appears afterwards.
// 6. ADD_SUB_MODE_EN, sub=1: A=5, B=7, Cin=0 -> S=0xFFFFFFFE, Cout=0.
//    - Also sweep SEG=32 (latency 1) and SEG=4 (latency 8).

Source files
------------

// File: rtl/pipelined_segment_adder.sv
// Segmented, pipelined WIDTH-bit adder: one SEG-bit slice per stage,
// carry registered between stages. Optional subtract mode: ADD_SUB_MODE_EN.
module pipelined_segment_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef ADD_SUB_MODE_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam bit CFG_OK = (SEG >= 1) && (SEG <= WIDTH);
   localparam int SEG_D  = CFG_OK ? SEG : 1;
   localparam int STAGES = CFG_OK ? (WIDTH / SEG_D) : 1;

   generate
      if (!CFG_OK || ((WIDTH % SEG_D) != 0)) begin : g_bad_cfg
         $error("pipelined_segment_adder: WIDTH must be a multiple of SEG, SEG in 1..WIDTH");
      end
   endgenerate

   // Per-stage state: valid, remaining operands, partial sum, carry
   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [STAGES-1:0] c_q;

   // Stage inputs and next-state values
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [WIDTH-1:0]  s_nx [STAGES];
   logic [STAGES-1:0] c_in;
   logic [STAGES-1:0] c_nx;
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] rdy;
   logic [SEG_D:0]    t;
   logic              acc;

   // Subtract folds into the entry: invert B and the carry once,
   // so later stages only ever see a plain add.
   logic [WIDTH-1:0] b0;
   logic             c0;
`ifdef ADD_SUB_MODE_EN
   assign b0 = sub ? ~B : B;
   assign c0 = sub ? ~Cin : Cin;
`else
   assign b0 = B;
   assign c0 = Cin;
`endif

   // Bubble-collapsing ready: a stage can load if it, or any stage
   // downstream of it, is empty, or the consumer is taking the result.
   always_comb begin
      acc = out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc    = acc | ~v[k];
         rdy[k] = acc;
      end
   end

   // Route each stage's inputs from its upstream neighbour
   always_comb begin
      a_in[0] = A;
      b_in[0] = b0;
      c_in[0] = c0;
      s_in[0] = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         s_in[k] = s_q[k-1];
         v_in[k] = v[k-1];
      end
   end

   // Add this stage's segment and splice it into the partial sum
   always_comb begin
      t    = '0;
      c_nx = '0;
      for (int k = 0; k < STAGES; k++) begin
         t = {1'b0, a_in[k][k*SEG_D +: SEG_D]}
           + {1'b0, b_in[k][k*SEG_D +: SEG_D]}
           + {{SEG_D{1'b0}}, c_in[k]};
         s_nx[k]                  = s_in[k];
         s_nx[k][k*SEG_D +: SEG_D] = t[SEG_D-1:0];
         c_nx[k]                  = t[SEG_D];
      end
   end

   // Stage registers: valid follows upstream when ready, data only on valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v   <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v[k] <= v_in[k];
               if (v_in[k]) begin
                  a_q[k] <= a_in[k];
                  b_q[k] <= b_in[k];
                  s_q[k] <= s_nx[k];
                  c_q[k] <= c_nx[k];
               end
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[STAGES-1];
   assign S         = s_q[STAGES-1];
   assign Cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (WIDTH=32, SEG=8).
module tb_pipelined_segment_adder;

   localparam int W      = 32;
   localparam int SG     = 8;
   localparam int STAGES = W / SG;
   localparam int N5     = (STAGES < 3) ? STAGES : 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  S;
   logic          Cout;
`ifdef ADD_SUB_MODE_EN
   logic          sub = 1'b0;
`endif

   pipelined_segment_adder #(.WIDTH(W), .SEG(SG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
`ifdef ADD_SUB_MODE_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          out_cnt = 0;
   logic [W:0]  q[$];
   int          out_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output transfer is checked against the queue head
   always @(negedge clk) begin
      logic [W:0] e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got S=%h Cout=%b, none queued", S, Cout);
         end else begin
            e = q.pop_front();
            if ({Cout, S} !== e) begin
               errors++;
               $display("FAIL result got S=%h Cout=%b want S=%h Cout=%b",
                        S, Cout, e[W-1:0], e[W]);
            end
         end
         out_cnt++;
         out_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W:0] exp, output int waits);
      A = a; B = b; Cin = c; in_valid = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         waits++;
         if (waits > 200) begin
            $display("FAIL send_timeout in_ready never rose");
            $fatal(1);
         end
      end
      q.push_back(exp);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending want 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   logic [W-1:0] ta [8] = '{32'h00000001, 32'h0000000A, 32'hFFFF0000, 32'h0F0F0F0F,
                            32'hAAAAAAAA, 32'h7FFFFFFF, 32'h00FF00FF, 32'hFFFFFFFF};
   logic [W-1:0] tb [8] = '{32'h00000002, 32'h00000014, 32'h00010000, 32'hF0F0F0F0,
                            32'h55555555, 32'h00000001, 32'h00FF00FF, 32'hFFFFFFFF};
   logic         tc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [W:0]   te [8] = '{33'h000000003, 33'h00000001F, 33'h100000000, 33'h100000000,
                            33'h0FFFFFFFF, 33'h080000000, 33'h001FE01FE, 33'h1FFFFFFFF};

   initial begin
      int w;
      int lat;
      int base;
      logic [W-1:0] ra, rb;
      logic rc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
      chk("rst_S_Cout", {Cout, S}, 33'd0);
      chk("rst_in_ready", {32'd0, in_ready}, 33'd1);

      // 1: wrap-around and latency
      @(posedge clk); #1;
      send(32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h100000000, w);
      lat = 1;
      while (lat < 50) begin
         @(negedge clk);
         if (out_valid === 1'b1) break;
         @(posedge clk);
         lat++;
      end
      chk("latency", lat, STAGES);
      drain();

      // 2: carry across the seg0/seg1 boundary, plus a few more directed
      send(32'h000000FF, 32'h00000001, 1'b1, 33'h000000101, w);
      send(32'h80000000, 32'h80000000, 1'b0, 33'h100000000, w);
      send(32'h12345678, 32'h11111111, 1'b1, 33'h02345678A, w);
      drain();

      // 3: 16 back-to-back with out_ready=1
      out_cyc.delete();
      for (int i = 0; i < 16; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         send(ra, rb, rc, model(ra, rb, rc), w);
         chk("b2b_in_ready_wait", w, 0);
      end
      drain();
      chk("b2b_count", out_cyc.size(), 16);
      if (out_cyc.size() == 16)
         chk("b2b_consecutive", out_cyc[15] - out_cyc[0], 15);

      // 4: fill with out_ready=0, stall, then drain
      out_ready = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         send(ta[k % 8], tb[k % 8], tc[k % 8], te[k % 8], w);
         chk("fill_wait", w, 0);
      end
      A = 32'hDEADBEEF; B = 32'hCAFEF00D; Cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
         chk("stall_out_valid", {32'd0, out_valid}, 33'd1);
         chk("stall_hold", {Cout, S}, te[0]);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      base = out_cnt;
      drain();
      chk("stall_drain_count", out_cnt - base, STAGES);

      // 5: reset with results in flight
      out_ready = 1'b0;
      for (int k = 0; k < N5; k++)
         send(ta[k + 4], tb[k + 4], tc[k + 4], te[k + 4], w);
      rst_n = 1'b0;
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("rst2_out_valid", {32'd0, out_valid}, 33'd0);
      chk("rst2_S_Cout", {Cout, S}, 33'd0);
      chk("rst2_in_ready", {32'd0, in_ready}, 33'd1);
      base = out_cnt;
      repeat (10) @(negedge clk);
      chk("rst2_no_stale", out_cnt - base, 0);
      @(posedge clk); #1;

`ifdef ADD_SUB_MODE_EN
      // 6: subtract mode
      sub = 1'b1;
      send(32'd5, 32'd7, 1'b0, 33'h0FFFFFFFE, w);
      send(32'd7, 32'd5, 1'b0, 33'h100000002, w);
      send(32'd7, 32'd5, 1'b1, 33'h100000001, w);
      sub = 1'b0;
      send(32'd5, 32'd7, 1'b0, 33'h00000000C, w);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
